// File: rtl/apb_spi_seq_arbiter_if.sv
// APB bus between the request sequencer (master) and apb_spi_master (slave).
interface apb_spi_seq_arbiter_if;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_spi_seq_arbiter.sv
// Round-robin arbiter turning single-word SPI requests into apb_spi_master register sequences.
// Optional CLKDIV programming before each transfer: `define SPI_SEQ_CLKDIV_EN.
module apb_spi_seq_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_rd,
  input  logic [2*N_REQ-1:0]   req_cs,
  input  logic [6*N_REQ-1:0]   req_len,
  input  logic [32*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
`ifdef SPI_SEQ_CLKDIV_EN
  input  logic [7:0]           cfg_clkdiv,
`endif
  apb_spi_seq_arbiter_if.master apb
);

  localparam int unsigned IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PCW = $clog2(POLL_MAX + 1);
  localparam int unsigned GCW = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_DIV, S_W_LEN, S_W_TX, S_W_CMD,
    S_POLL_WAIT, S_POLL_RD, S_R_RX, S_ABORT, S_RESP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic           rd_q, rd_d;
  logic [1:0]     cs_q, cs_d;
  logic [5:0]     len_q, len_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [GCW-1:0] gap_q, gap_d;
`ifdef SPI_SEQ_CLKDIV_EN
  logic [7:0]     div_q, div_d;
  logic [7:0]     shadow_q, shadow_d;
  logic           div_fresh_q, div_fresh_d;
`endif

  logic           win_found;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  cand_idx;
  int unsigned    cand;
  logic           sel_rd;
  logic [1:0]     sel_cs;
  logic [5:0]     sel_len;
  logic [31:0]    sel_wdata;
  logic           access_st;

  // First valid requester at or after rr_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    sel_rd    = 1'b0;
    sel_cs    = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
        sel_rd    = req_rd[cand_idx];
        sel_cs    = req_cs[2*cand +: 2];
        sel_len   = req_len[6*cand +: 6];
        sel_wdata = req_wdata[32*cand +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state_q == S_RESP) begin
      rsp_valid[gnt_q] = 1'b1;
      rsp_rdata        = rdata_q;
      rsp_err          = err_q;
    end
  end

  // APB outputs decode straight from registers so reset clears them without a clock.
  always_comb begin
    access_st   = 1'b1;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    apb.PWRITE  = 1'b0;
    case (state_q)
`ifdef SPI_SEQ_CLKDIV_EN
      S_W_DIV:   begin apb.PADDR = 12'h004; apb.PWRITE = 1'b1; apb.PWDATA = {24'b0, div_q}; end
`endif
      S_W_LEN:   begin apb.PADDR = 12'h010; apb.PWRITE = 1'b1; apb.PWDATA = {10'b0, len_q, 16'b0}; end
      S_W_TX:    begin apb.PADDR = 12'h018; apb.PWRITE = 1'b1; apb.PWDATA = wdata_q; end
      S_W_CMD:   begin
        apb.PADDR  = 12'h000;
        apb.PWRITE = 1'b1;
        apb.PWDATA = {20'b0, 4'(4'b0001 << cs_q), 6'b0, ~rd_q, rd_q};
      end
      S_POLL_RD: apb.PADDR = 12'h000;
      S_R_RX:    apb.PADDR = 12'h020;
      S_ABORT:   begin apb.PADDR = 12'h000; apb.PWRITE = 1'b1; apb.PWDATA = 32'h10; end
      default:   access_st = 1'b0;
    endcase
    apb.PSEL    = access_st && (phase_q != PH_GAP);
    apb.PENABLE = access_st && (phase_q == PH_ACCESS);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    cs_d    = cs_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    poll_d  = poll_q;
    gap_d   = gap_q;
`ifdef SPI_SEQ_CLKDIV_EN
    div_d       = div_q;
    shadow_d    = shadow_q;
    div_fresh_d = div_fresh_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          rr_d    = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
          gnt_d   = win_idx;
          rd_d    = sel_rd;
          cs_d    = sel_cs;
          len_d   = sel_len;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          phase_d = PH_SETUP;
          if (sel_len == 6'd0 || sel_len > 6'd32) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
`ifdef SPI_SEQ_CLKDIV_EN
            div_d   = cfg_clkdiv;
            state_d = (div_fresh_q || cfg_clkdiv != shadow_q) ? S_W_DIV : S_W_LEN;
`else
            state_d = S_W_LEN;
`endif
          end
        end
      end
      S_POLL_WAIT: begin
        if (32'(gap_q) + 32'd1 >= POLL_GAP) begin
          state_d = S_POLL_RD;
          phase_d = PH_SETUP;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        case (phase_q)
          PH_SETUP: phase_d = PH_ACCESS;
          PH_ACCESS: begin
            if (apb.PREADY) begin
              // Completion always leaves one idle cycle with PSEL low before the next SETUP.
              phase_d = PH_GAP;
              if (apb.PSLVERR) begin
                err_d   = 1'b1;
                state_d = S_RESP;
              end else begin
                case (state_q)
                  S_W_DIV: begin
`ifdef SPI_SEQ_CLKDIV_EN
                    shadow_d    = div_q;
                    div_fresh_d = 1'b0;
`endif
                    state_d = S_W_LEN;
                  end
                  S_W_LEN: state_d = rd_q ? S_W_CMD : S_W_TX;
                  S_W_TX:  state_d = S_W_CMD;
                  S_W_CMD: begin
                    state_d = S_POLL_WAIT;
                    poll_d  = '0;
                    gap_d   = '0;
                  end
                  S_POLL_RD: begin
                    if (apb.PRDATA[0]) begin
                      state_d = rd_q ? S_R_RX : S_RESP;
                    end else if (32'(poll_q) + 32'd1 >= POLL_MAX) begin
                      state_d = S_ABORT;
                    end else begin
                      poll_d  = poll_q + 1'b1;
                      gap_d   = '0;
                      state_d = S_POLL_WAIT;
                    end
                  end
                  S_R_RX: begin
                    rdata_d = apb.PRDATA;
                    state_d = S_RESP;
                  end
                  S_ABORT: begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                  end
                  default: state_d = S_IDLE;
                endcase
              end
            end
          end
          default: phase_d = PH_SETUP;
        endcase
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      phase_q <= PH_SETUP;
      rr_q    <= '0;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      cs_q    <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      poll_q  <= '0;
      gap_q   <= '0;
`ifdef SPI_SEQ_CLKDIV_EN
      div_q       <= '0;
      shadow_q    <= '0;
      div_fresh_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
`ifdef SPI_SEQ_CLKDIV_EN
      div_q       <= div_d;
      shadow_q    <= shadow_d;
      div_fresh_q <= div_fresh_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_spi_seq_arbiter.sv
// Directed bench: APB slave model plus bus/grant/response logs checked against hand-computed values.
module tb_apb_spi_seq_arbiter;
  localparam int unsigned N = 2;

  logic           HCLK;
  logic           HRESETn;
  logic [N-1:0]   req_valid, req_ready, req_rd, rsp_valid;
  logic [2*N-1:0] req_cs;
  logic [6*N-1:0] req_len;
  logic [32*N-1:0] req_wdata;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
`ifdef SPI_SEQ_CLKDIV_EN
  logic [7:0]     cfg_clkdiv;
  assign cfg_clkdiv = 8'd3;
`endif

  apb_spi_seq_arbiter_if apb ();

  apb_spi_seq_arbiter #(.N_REQ(N), .POLL_MAX(8), .POLL_GAP(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_cs    (req_cs),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
`ifdef SPI_SEQ_CLKDIV_EN
    .cfg_clkdiv(cfg_clkdiv),
`endif
    .apb       (apb)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // slave model controls
  int          stat_thresh = 0;
  logic [31:0] rx_word     = '0;
  logic        err_en      = 1'b0;
  logic [11:0] err_addr    = '0;
  int          wait_states = 0;
  int          acc_wait    = 0;

  // logs written only by the monitor
  int          cyc = 0;
  int          log_n = 0, stat_reads = 0, psel_cnt = 0, gnt_n = 0, rsp_n = 0;
  logic [11:0] log_addr [256];
  logic        log_wr   [256];
  logic [31:0] log_wd   [256];
  int          gnt_who  [256];
  int          gnt_cyc  [256];
  int          rsp_who  [256];
  int          rsp_cyc  [256];
  logic        rsp_e    [256];
  logic [31:0] rsp_d    [256];

  always @(negedge HCLK) begin
    if (apb.PSEL && apb.PENABLE) begin
      if (acc_wait < wait_states) begin
        apb.PREADY <= 1'b0;
        acc_wait   <= acc_wait + 1;
      end else begin
        apb.PREADY  <= 1'b1;
        apb.PSLVERR <= err_en && (apb.PADDR == err_addr);
        if (apb.PADDR == 12'h000) apb.PRDATA <= (stat_reads < stat_thresh) ? 32'd0 : 32'd1;
        else if (apb.PADDR == 12'h020) apb.PRDATA <= rx_word;
        else apb.PRDATA <= 32'd0;
      end
    end else begin
      apb.PREADY  <= 1'b0;
      apb.PSLVERR <= 1'b0;
      apb.PRDATA  <= '0;
      acc_wait    <= 0;
    end
  end

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (apb.PSEL) psel_cnt <= psel_cnt + 1;
    if (apb.PSEL && apb.PENABLE && apb.PREADY && log_n < 256) begin
      log_addr[log_n] <= apb.PADDR;
      log_wr[log_n]   <= apb.PWRITE;
      log_wd[log_n]   <= apb.PWDATA;
      log_n           <= log_n + 1;
      if (!apb.PWRITE && apb.PADDR == 12'h000) stat_reads <= stat_reads + 1;
    end
    if (req_ready != '0 && gnt_n < 256) begin
      gnt_who[gnt_n] <= req_ready[1] ? 1 : 0;
      gnt_cyc[gnt_n] <= cyc;
      gnt_n          <= gnt_n + 1;
    end
    if (rsp_valid != '0 && rsp_n < 256) begin
      rsp_who[rsp_n] <= rsp_valid[1] ? 1 : 0;
      rsp_cyc[rsp_n] <= cyc;
      rsp_e[rsp_n]   <= rsp_err;
      rsp_d[rsp_n]   <= rsp_rdata;
      rsp_n          <= rsp_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_fields(input int i, input logic rd, input logic [1:0] cs,
                            input logic [5:0] len, input logic [31:0] wd);
    req_rd[i]            = rd;
    req_cs[2*i +: 2]     = cs;
    req_len[6*i +: 6]    = len;
    req_wdata[32*i +: 32] = wd;
  endtask

  task automatic wait_gnt(input int target, input int budget);
    int b = 0;
    while (gnt_n < target && b < budget) begin tick(); b++; end
    chk("grant_seen", 32'(gnt_n >= target), 32'd1);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int b = 0;
    while (rsp_n < target && b < budget) begin tick(); b++; end
    chk("rsp_seen", 32'(rsp_n >= target), 32'd1);
  endtask

  task automatic issue(input int i, input logic rd, input logic [1:0] cs,
                       input logic [5:0] len, input logic [31:0] wd);
    int g0;
    g0 = gnt_n;
    set_fields(i, rd, cs, len, wd);
    req_valid[i] = 1'b1;
    wait_gnt(g0 + 1, 50);
    req_valid[i] = 1'b0;
    chk("grant_who", 32'(gnt_who[g0]), 32'(i));
  endtask

  task automatic chk_acc(input string tag, input int k, input logic [11:0] a,
                         input logic w, input logic [31:0] d);
    chk({tag, "_addr"}, 32'(log_addr[k]), 32'(a));
    chk({tag, "_write"}, 32'(log_wr[k]), 32'(w));
    if (w) chk({tag, "_wdata"}, log_wd[k], d);
  endtask

  task automatic chk_rsp(input string tag, input int k, input int who,
                         input logic e, input logic [31:0] d);
    chk({tag, "_who"}, 32'(rsp_who[k]), 32'(who));
    chk({tag, "_err"}, 32'(rsp_e[k]), 32'(e));
    chk({tag, "_rdata"}, rsp_d[k], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, rb, gb, p0;
    HRESETn   = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_cs    = '0;
    req_len   = '0;
    req_wdata = '0;
    repeat (3) tick();

    chk("rst_psel", 32'(apb.PSEL), 32'd0);
    chk("rst_penable", 32'(apb.PENABLE), 32'd0);
    chk("rst_paddr", 32'(apb.PADDR), 32'd0);
    chk("rst_pwdata", apb.PWDATA, 32'd0);
    chk("rst_pwrite", 32'(apb.PWRITE), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    HRESETn = 1'b1;
    tick();

    // write, cs=1, len=8, two busy polls
    lb = log_n; rb = rsp_n;
    stat_thresh = stat_reads + 2;
    issue(0, 1'b0, 2'd1, 6'd8, 32'hA5);
    wait_rsp(rb + 1, 300);
    chk("t1_count", 32'(log_n - lb), 32'd6);
    chk_acc("t1_len", lb, 12'h010, 1'b1, 32'h0008_0000);
    chk_acc("t1_tx", lb + 1, 12'h018, 1'b1, 32'h0000_00A5);
    chk_acc("t1_cmd", lb + 2, 12'h000, 1'b1, 32'h0000_0202);
    for (int k = 3; k < 6; k++) chk_acc("t1_poll", lb + k, 12'h000, 1'b0, 32'd0);
    chk_rsp("t1_rsp", rb, 0, 1'b0, 32'd0);

    // read, cs=0, len=32
    lb = log_n; rb = rsp_n;
    stat_thresh = stat_reads;
    rx_word = 32'hDEAD_BEEF;
    issue(1, 1'b1, 2'd0, 6'd32, 32'd0);
    wait_rsp(rb + 1, 300);
    chk("t2_count", 32'(log_n - lb), 32'd4);
    chk_acc("t2_len", lb, 12'h010, 1'b1, 32'h0020_0000);
    chk_acc("t2_cmd", lb + 1, 12'h000, 1'b1, 32'h0000_0101);
    chk_acc("t2_poll", lb + 2, 12'h000, 1'b0, 32'd0);
    chk_acc("t2_rx", lb + 3, 12'h020, 1'b0, 32'd0);
    chk_rsp("t2_rsp", rb, 1, 1'b0, 32'hDEAD_BEEF);

    // illegal lengths: no bus activity, response one cycle after accept
    p0 = psel_cnt; rb = rsp_n; gb = gnt_n;
    issue(0, 1'b0, 2'd0, 6'd0, 32'h1);
    wait_rsp(rb + 1, 20);
    chk("t3_len0_lat", 32'(rsp_cyc[rb] - gnt_cyc[gb]), 32'd1);
    chk_rsp("t3_len0", rb, 0, 1'b1, 32'd0);
    issue(1, 1'b1, 2'd2, 6'd40, 32'h2);
    wait_rsp(rb + 2, 20);
    chk("t3_len40_lat", 32'(rsp_cyc[rb + 1] - gnt_cyc[gb + 1]), 32'd1);
    chk_rsp("t3_len40", rb + 1, 1, 1'b1, 32'd0);
    chk("t3_no_psel", 32'(psel_cnt - p0), 32'd0);

    // both requesters held: alternation
    gb = gnt_n; rb = rsp_n;
    set_fields(0, 1'b0, 2'd0, 6'd0, 32'd0);
    set_fields(1, 1'b0, 2'd0, 6'd0, 32'd0);
    req_valid = 2'b11;
    wait_gnt(gb + 4, 50);
    req_valid = 2'b00;
    wait_rsp(rb + 4, 20);
    chk("t4_g0", 32'(gnt_who[gb]), 32'd0);
    chk("t4_g1", 32'(gnt_who[gb + 1]), 32'd1);
    chk("t4_g2", 32'(gnt_who[gb + 2]), 32'd0);
    chk("t4_g3", 32'(gnt_who[gb + 3]), 32'd1);

    // requester 1 arrives first, then both held
    gb = gnt_n; rb = rsp_n;
    req_valid[1] = 1'b1;
    wait_gnt(gb + 1, 20);
    req_valid[0] = 1'b1;
    wait_gnt(gb + 4, 50);
    req_valid = 2'b00;
    wait_rsp(rb + 4, 20);
    chk("t4r_g0", 32'(gnt_who[gb]), 32'd1);
    chk("t4r_g1", 32'(gnt_who[gb + 1]), 32'd0);
    chk("t4r_g2", 32'(gnt_who[gb + 2]), 32'd1);
    chk("t4r_g3", 32'(gnt_who[gb + 3]), 32'd0);

    // STATUS never idle: 8 polls then soft reset
    lb = log_n; rb = rsp_n;
    stat_thresh = stat_reads + 1000;
    issue(0, 1'b0, 2'd2, 6'd16, 32'h1234);
    wait_rsp(rb + 1, 500);
    stat_thresh = stat_reads;
    chk("t5_count", 32'(log_n - lb), 32'd12);
    chk_acc("t5_cmd", lb + 2, 12'h000, 1'b1, 32'h0000_0402);
    for (int k = 3; k < 11; k++) chk_acc("t5_poll", lb + k, 12'h000, 1'b0, 32'd0);
    chk_acc("t5_abort", lb + 11, 12'h000, 1'b1, 32'h0000_0010);
    chk_rsp("t5_rsp", rb, 0, 1'b1, 32'd0);

    // slave error on TXFIFO write
    lb = log_n; rb = rsp_n;
    err_en = 1'b1; err_addr = 12'h018;
    issue(1, 1'b0, 2'd3, 6'd8, 32'h55);
    wait_rsp(rb + 1, 100);
    repeat (10) tick();
    err_en = 1'b0;
    chk("t6_count", 32'(log_n - lb), 32'd2);
    chk_acc("t6_tx", lb + 1, 12'h018, 1'b1, 32'h0000_0055);
    chk_rsp("t6_rsp", rb, 1, 1'b1, 32'd0);

    // wait states: ACCESS held stable while PREADY low
    lb = log_n; rb = rsp_n;
    wait_states = 5;
    issue(0, 1'b0, 2'd0, 6'd4, 32'h5A);
    chk("t7_setup_psel", 32'(apb.PSEL), 32'd1);
    chk("t7_setup_pen", 32'(apb.PENABLE), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t7_psel", 32'(apb.PSEL), 32'd1);
      chk("t7_pen", 32'(apb.PENABLE), 32'd1);
      chk("t7_paddr", 32'(apb.PADDR), 32'h010);
      chk("t7_pwdata", apb.PWDATA, 32'h0004_0000);
      chk("t7_pwrite", 32'(apb.PWRITE), 32'd1);
      tick();
    end
    wait_rsp(rb + 1, 400);
    wait_states = 0;
    chk("t7_count", 32'(log_n - lb), 32'd4);
    chk_rsp("t7_rsp", rb, 0, 1'b0, 32'd0);

    // reset in the middle of an ACCESS
    rb = rsp_n;
    wait_states = 50;
    issue(0, 1'b0, 2'd1, 6'd8, 32'h77);
    tick();
    chk("t8_in_access", 32'(apb.PENABLE), 32'd1);
    #3 HRESETn = 1'b0;
    #1;
    chk("t8_psel", 32'(apb.PSEL), 32'd0);
    chk("t8_penable", 32'(apb.PENABLE), 32'd0);
    chk("t8_paddr", 32'(apb.PADDR), 32'd0);
    chk("t8_pwdata", apb.PWDATA, 32'd0);
    chk("t8_pwrite", 32'(apb.PWRITE), 32'd0);
    chk("t8_rspv", 32'(rsp_valid), 32'd0);
    wait_states = 0;
    repeat (2) tick();
    HRESETn = 1'b1;
    p0 = psel_cnt;
    repeat (20) tick();
    chk("t8_no_rsp", 32'(rsp_n - rb), 32'd0);
    chk("t8_no_psel", 32'(psel_cnt - p0), 32'd0);

    // pointer back at requester 0 after reset
    gb = gnt_n; rb = rsp_n;
    req_valid = 2'b11;
    wait_gnt(gb + 1, 20);
    req_valid = 2'b00;
    wait_rsp(rb + 1, 20);
    chk("t8_rr_reset", 32'(gnt_who[gb]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_spi_seq_arbiter.md
Name: apb_spi_seq_arbiter

Overview:
- Round-robin arbiter and transaction sequencer in front of apb_spi_master's APB slave port.
- Accepts single-word SPI read/write requests from N_REQ local requesters.
- Translates each request into the APB register-write/poll/read sequence the SPI master needs, and returns one response per request.
- Sole APB master of apb_spi_master (drives its PADDR/PWDATA/PWRITE/PSEL/PENABLE).

Parameters:
- N_REQ, 2, number of requesters (2..4)
- POLL_MAX, 1024, max STATUS polls before timeout
- POLL_GAP, 4, HCLK idle cycles between command write and first poll, and between polls

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  one-hot accept pulse
- req_rd  in  N_REQ  1=SPI read, 0=SPI write
- req_cs  in  2*N_REQ  chip select 0..3, per requester
- req_len  in  6*N_REQ  bit count, valid 1..32
- req_wdata  in  32*N_REQ  TX word
- rsp_valid  out  N_REQ  one-hot one-cycle response strobe
- rsp_rdata  out  32  RX word (0 for writes and errors)
- rsp_err  out  1  response error flag
- PADDR  out  12  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB write
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; RR pointer selects requester 0 as highest priority.
- SPI master register map (decided):
  - STATUS 0x00. Write: bit0 rd, bit1 wr, bit4 swrst, bits[11:8] one-hot CS. Read: bit0=1 when idle.
  - CLKDIV 0x04.
  - SPILEN 0x10, data length in bits [31:16].
  - TXFIFO 0x18.
  - RXFIFO 0x20.
- Arbitration (IDLE): winner is the first set req_valid at or after rr_ptr. req_ready[winner] pulses 1 cycle; fields are latched that cycle. rr_ptr becomes winner+1 mod N_REQ. Requesters hold fields stable until accepted.
- Length check: latched len of 0 or >32 skips all APB traffic. RESP follows next cycle with err=1.
- APB transfer (each access):
  - SETUP: PSEL=1, PENABLE=0, 1 cycle.
  - ACCESS: PENABLE=1, held until PREADY.
  - PSEL/PENABLE then return to 0 for at least 1 cycle.
  - PADDR/PWDATA/PWRITE are stable from SETUP through completion.
- Write request states: W_LEN (SPILEN=len<<16) -> W_TX (TXFIFO=wdata) -> W_CMD (STATUS=(1<<(8+cs))|0x2) -> POLL -> RESP.
- Read request states: W_LEN -> W_CMD (STATUS=(1<<(8+cs))|0x1) -> POLL -> R_RX (read RXFIFO, capture PRDATA) -> RESP.
- POLL:
  - Wait POLL_GAP cycles, then read STATUS.
  - PRDATA[0]=1 -> next state.
  - Otherwise increment poll counter and repeat.
  - Counter reaching POLL_MAX -> ABORT.
- ABORT: write STATUS=0x10 (swrst), then RESP with err=1.
- PSLVERR=1 on any completed access: stop the sequence immediately (no further accesses), RESP err=1.
- RESP: rsp_valid[granted]=1 for 1 cycle with rsp_rdata/rsp_err valid, then IDLE. A new grant can be issued the following cycle.
- Requests arriving mid-sequence wait; there is no preemption. Deasserting req_valid before accept withdraws the request.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, no response is issued, and the request is lost.

Optional Feature:
- Macro: SPI_SEQ_CLKDIV_EN.
- Defined:
  - Adds input cfg_clkdiv[7:0].
  - Before W_LEN, write CLKDIV=cfg_clkdiv if the value differs from the last written value, or if no write has occurred since reset.
  - Shadow register resets to 0 with a "never written" flag set.
- Undefined: no port, CLKDIV is never written.

Test Plan:
- Req0 write, cs=1, len=8, wdata=0xA5: APB writes 0x10=0x00080000, 0x18=0xA5, 0x00=0x202. Poll returns 0 twice then 1 -> rsp_valid[0], err=0, rdata=0.
- Req1 read, cs=0, len=32: 0x10=0x00200000, 0x00=0x101, poll idle, RXFIFO PRDATA=0xDEADBEEF -> rsp_valid[1], rdata=0xDEADBEEF.
- Req0 and req1 both held valid for 4 transactions: grants alternate 0,1,0,1. Reorder back-to-back and check grants still alternate.
- len=0 and len=40: no PSEL activity, rsp_err=1 one cycle after accept.
- STATUS held 0 with POLL_MAX=8: exactly 8 polls, then 0x00=0x10 write, rsp_err=1. PSLVERR on the TXFIFO write: no further APB accesses, rsp_err=1.
- PREADY held low 5 cycles in ACCESS: signals held stable. HRESETn asserted mid-ACCESS: all outputs 0 immediately.
